// File: rtl/alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dmem
//
// Purpose:
//   Two datapath helpers that share one clock:
//   - the ALU control decoder, which maps the main-control operation class
//     (alu_op) and the R-type function field (funct) to a 4-bit ALU
//     operation code. It is purely combinational and ignores reset.
//   - a word-organised data memory with a combinational read port, a
//     synchronous write port and a free-running cycle counter.
//
// Optional feature:
//   ALU_CTRL_SHIFT_EN - when defined, funct 000000 (sll) decodes to 0011 and
//                       funct 000010 (srl) decodes to 0100. When undefined,
//                       both decode to 1111 (invalid).
//
// Parameters:
//   MEM_WORDS   number of 32-bit memory words (power of two, 16..4096)
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   alu_op       in   2   ALU operation class from main control
//   funct        in   6   R-type function field
//   operation    out  4   ALU operation code
//   address      in  32   data-memory byte address
//   write_data   in  32   store data
//   mem_read     in   1   load enable
//   mem_write    in   1   store enable
//   read_data    out 32   load data (0 when not reading or out of range)
//   cycle_count  out 32   free-running cycle counter, cleared by reset
//
// Interface timing:
//   The memory has no handshake. A store takes effect at the rising edge on
//   which mem_write=1, rst=0 and the address is in range. A load is visible
//   in the same cycle in which mem_read=1 is presented.
// -----------------------------------------------------------------------------
module alu_ctrl_dmem #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  output logic [3:0]  operation,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [31:0] cycle_count
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] word_index;
  logic          in_range;

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    operation = 4'b1111;
    case (alu_op)
      2'b00: operation = 4'b0010;  // add for load/store address
      2'b01: operation = 4'b0110;  // sub for branch compare
      2'b11: operation = 4'b0001;  // or
      2'b10: begin
        case (funct)
          6'b100000: operation = 4'b0010;  // add
          6'b100010: operation = 4'b0110;  // sub
          6'b100100: operation = 4'b0000;  // and
          6'b100101: operation = 4'b0001;  // or
          6'b100111: operation = 4'b1100;  // nor
          6'b101010: operation = 4'b0111;  // slt
`ifdef ALU_CTRL_SHIFT_EN
          6'b000000: operation = 4'b0011;  // sll
          6'b000010: operation = 4'b0100;  // srl
`endif
          default:   operation = 4'b1111;
        endcase
      end
      default: operation = 4'b1111;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  // Byte offset bits [1:0] are ignored; any set bit above the word index
  // places the address outside the memory.
  assign word_index = address[AW+1:2];
  assign in_range   = (address[31:AW+2] == '0);

  // Read returns the stored contents before any same-cycle write lands,
  // since the array only updates at the clock edge.
  assign read_data = (mem_read && in_range) ? mem[word_index] : 32'd0;

  // Reset clears every word and wins over a simultaneous store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
      cycle_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (mem_write && in_range) begin
        mem[word_index] <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_dmem
//
// Self-checking bench for alu_ctrl_dmem. A behavioural model (a word array,
// a cycle counter and a decode table) follows the same inputs as the DUT.
// Directed scenarios come first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_dmem;

  localparam int MEM_WORDS = 256;
  localparam int N_RANDOM  = 400;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  alu_op     = 2'b00;
  logic [5:0]  funct      = 6'd0;
  logic [3:0]  operation;
  logic [31:0] address    = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        mem_read   = 1'b0;
  logic        mem_write  = 1'b0;
  logic [31:0] read_data;
  logic [31:0] cycle_count;

  alu_ctrl_dmem #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_op      (alu_op),
    .funct       (funct),
    .operation   (operation),
    .address     (address),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .read_data   (read_data),
    .cycle_count (cycle_count)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] model_cycles;

  logic [5:0] funct_pool [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100111, 6'b101010, 6'b000000, 6'b000010,
                                  6'b111111, 6'b000001};

  function automatic logic [3:0] model_op(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd1;
    if (fn == 6'd32) return 4'd2;
    if (fn == 6'd34) return 4'd6;
    if (fn == 6'd36) return 4'd0;
    if (fn == 6'd37) return 4'd1;
    if (fn == 6'd39) return 4'd12;
    if (fn == 6'd42) return 4'd7;
`ifdef ALU_CTRL_SHIFT_EN
    if (fn == 6'd0) return 4'd3;
    if (fn == 6'd2) return 4'd4;
`endif
    return 4'd15;
  endfunction

  function automatic bit model_in_range(input logic [31:0] a);
    return a < 32'(4 * MEM_WORDS);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    if (rd && model_in_range(a)) return model_mem[a / 4];
    return 32'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One rising edge: the model applies the inputs seen at that edge, then
  // control returns at the falling edge so new inputs can be driven.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 32'd0;
      model_cycles = 32'd0;
    end else begin
      model_cycles = model_cycles + 32'd1;
      if (mem_write && model_in_range(address)) model_mem[address / 4] = write_data;
    end
    @(negedge clk);
  endtask

  task automatic drive_mem(input logic [31:0] a, input logic [31:0] wd,
                           input logic rd, input logic wr);
    address    = a;
    write_data = wd;
    mem_read   = rd;
    mem_write  = wr;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd);
    drive_mem(a, wd, 1'b0, 1'b1);
    tick();
    mem_write = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive_mem(a, 32'd0, 1'b1, 1'b0);
    #1;
    check(tag, read_data, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_val;

    model_cycles = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 32'hxxxx_xxxx;

    // Reset, with operation checked while reset is asserted.
    @(negedge clk);
    rst = 1'b1;
    alu_op = 2'b01;
    #1;
    check("op_during_rst", {28'd0, operation}, 32'd6);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_cycle", cycle_count, 32'd0);
    load_check("rst_mem0", 32'h0, 32'd0);
    load_check("rst_memtop", 32'(4 * MEM_WORDS - 4), 32'd0);

    // Decode sweep.
    alu_op = 2'b00; funct = 6'b111111; #1;
    check("dec_00", {28'd0, operation}, 32'd2);
    alu_op = 2'b01; funct = 6'b100000; #1;
    check("dec_01", {28'd0, operation}, 32'd6);
    alu_op = 2'b11; #1;
    check("dec_11", {28'd0, operation}, 32'd1);
    alu_op = 2'b10; funct = 6'b101010; #1;
    check("dec_slt", {28'd0, operation}, 32'd7);
    funct = 6'b100111; #1;
    check("dec_nor", {28'd0, operation}, 32'd12);
    funct = 6'b111111; #1;
    check("dec_inv", {28'd0, operation}, 32'd15);
    funct = 6'b000000; #1;
`ifdef ALU_CTRL_SHIFT_EN
    check("dec_sll", {28'd0, operation}, 32'd3);
`else
    check("dec_sll", {28'd0, operation}, 32'd15);
`endif
    for (int i = 0; i < 64; i++) begin
      funct = 6'(i);
      #1;
      check("dec_sweep", {28'd0, operation}, {28'd0, model_op(2'b10, funct)});
    end

    // Store / load with byte offsets ignored.
    store(32'h10, 32'hDEAD_BEEF);
    load_check("ld_0x10", 32'h10, 32'hDEAD_BEEF);
    load_check("ld_0x13", 32'h13, 32'hDEAD_BEEF);
    drive_mem(32'h10, 32'd0, 1'b0, 1'b0);
    #1;
    check("rd_gated", read_data, 32'd0);

    // Out-of-range store must not alias onto word 0.
    store(32'h0, 32'h1234_5678);
    store(32'(4 * MEM_WORDS), 32'hAAAA_5555);
    load_check("oor_read", 32'(4 * MEM_WORDS), 32'd0);
    load_check("oor_word0", 32'h0, 32'h1234_5678);
    store(32'h8000_0004, 32'h5555_AAAA);
    load_check("oor_word1", 32'h4, 32'd0);

    // Read during write.
    store(32'h20, 32'd5);
    drive_mem(32'h20, 32'd9, 1'b1, 1'b1);
    #1;
    check("rdw_before", read_data, 32'd5);
    tick();
    mem_write = 1'b0;
    #1;
    check("rdw_after", read_data, 32'd9);

    // Reset together with a store: store lost, all words cleared.
    rst = 1'b1;
    drive_mem(32'h10, 32'hCAFE_F00D, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    mem_write = 1'b0;
    load_check("rstw_0x10", 32'h10, 32'd0);
    load_check("rstw_0x20", 32'h20, 32'd0);
    load_check("rstw_0x00", 32'h0, 32'd0);
    check("rstw_cycle0", cycle_count, 32'd0);
    tick(); tick(); tick();
    check("rstw_cycle3", cycle_count, 32'd3);

    // Randomized phase against the model. Expected values are queued and
    // popped in order so each check uses what the model predicted.
    for (int n = 0; n < N_RANDOM; n++) begin
      alu_op = 2'($urandom_range(0, 3));
      funct  = ($urandom_range(0, 1) == 0) ? funct_pool[$urandom_range(0, 9)]
                                           : 6'($urandom_range(0, 63));
      case ($urandom_range(0, 5))
        0, 1, 2: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        3:       a = 32'($urandom_range(0, MEM_WORDS - 1) * 4 + $urandom_range(0, 3));
        4:       a = 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 4095));
        default: a = $urandom | 32'h8000_0000;
      endcase
      wd = $urandom;
      drive_mem(a, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 49) == 0);
      #1;
      exp_q.push_back({28'd0, model_op(alu_op, funct)});
      exp_q.push_back(model_read(address, mem_read));
      exp_val = exp_q.pop_front();
      check("rnd_op", {28'd0, operation}, exp_val);
      exp_val = exp_q.pop_front();
      check("rnd_read", read_data, exp_val);
      tick();
      #1;
      check("rnd_cycle", cycle_count, model_cycles);
    end
    rst = 1'b0;

    // Sweep the first words after the random phase.
    for (int i = 0; i < 16; i++) begin
      load_check("final_mem", 32'(i * 4), model_mem[i]);
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl_dmem.md
ALU_CTRL_DMEM -- requirements
Module: alu_ctrl_dmem

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of 32-bit data-memory words; power of two, 16..4096.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port alu_op, input, 2: ALU operation class from main control.
REQ-005 Port funct, input, 6: R-type function field.
REQ-006 Port operation, output, 4: ALU operation code.
REQ-007 Port address, input, 32: data-memory byte address.
REQ-008 Port write_data, input, 32: data-memory store data.
REQ-009 Port mem_read, input, 1: load enable.
REQ-010 Port mem_write, input, 1: store enable.
REQ-011 Port read_data, output, 32: load data.
REQ-012 Port cycle_count, output, 32: free-running cycle counter, replacing the bench clock-generator bookkeeping.

Function
REQ-013 operation SHALL be purely combinational from alu_op and funct, with zero latency.
REQ-014 The alu_op decode SHALL be as follows.
- 00 -> 0010 (add; load/store).
- 01 -> 0110 (sub; branch compare).
- 11 -> 0001 (or).
- 10 -> decoded from funct per REQ-015.
REQ-015 The funct decode SHALL be as follows.
- 100000 -> 0010 (add).
- 100010 -> 0110 (sub).
- 100100 -> 0000 (and).
- 100101 -> 0001 (or).
- 100111 -> 1100 (nor).
- 101010 -> 0111 (slt).
- 000000 -> 0011 (sll).
- 000010 -> 0100 (srl).
- Any other funct -> 1111 (invalid).
REQ-016 Memory SHALL be word-organised; word index = address[log2(MEM_WORDS)+1:2]; address[1:0] ignored.
REQ-017 An address is out of range when any bit of address[31:log2(MEM_WORDS)+2] is nonzero.
REQ-018 Read SHALL be combinational: read_data = mem[index] when mem_read=1 and the address is in range; read_data = 0 otherwise.
REQ-019 Write SHALL occur at the rising clk edge when mem_write=1, rst=0 and the address is in range; out-of-range writes SHALL be silently dropped.
REQ-020 With mem_read and mem_write both high on the same address, read_data SHALL show the pre-write contents until the edge, then the new value.
REQ-021 cycle_count SHALL increment by 1 every rising edge with rst=0 and wrap from 0xFFFFFFFF to 0.

Reset
REQ-022 When rst=1 at a rising edge, all MEM_WORDS words SHALL become 0 and cycle_count SHALL become 0.
REQ-023 rst SHALL take priority over a simultaneous mem_write; the write is lost.
REQ-024 operation SHALL be unaffected by rst.
REQ-025 read_data SHALL read 0 from any in-range address after reset.
REQ-026 Reset asserted mid-sequence SHALL discard all prior stores.

Configuration
REQ-027 Macro ALU_CTRL_SHIFT_EN defined: funct 000000 and 000010 decode to 0011 and 0100 per REQ-015.
REQ-028 Macro ALU_CTRL_SHIFT_EN undefined: funct 000000 and 000010 decode to 1111 (invalid); all other decodes are unchanged.

Verification
REQ-029 Decode sweep:
- alu_op=00 with any funct -> 0010.
- alu_op=01 -> 0110.
- alu_op=10, funct=101010 -> 0111.
- alu_op=10, funct=100111 -> 1100.
- alu_op=10, funct=111111 -> 1111.
REQ-030 Store/load: write 0xDEADBEEF to address 0x10 with mem_write=1 for one edge, then mem_read=1 at 0x10 and at 0x13 -> read_data=0xDEADBEEF in both cases.
REQ-031 Read gating and range checks:
- mem_read=0 at 0x10 -> read_data=0.
- Store to byte address 4*MEM_WORDS -> dropped; the address reads 0 and word 0 is unchanged.
REQ-032 Read-during-write: word 0x20 holds 5; apply mem_write=1, mem_read=1, write_data=9 -> read_data=5 before the edge and 9 after it.
REQ-033 Reset with write: rst=1 together with mem_write to 0x10 -> after the edge, read_data at 0x10 = 0 and cycle_count=0; cycle_count = 3 after three further edges.
REQ-034 Shift option: with ALU_CTRL_SHIFT_EN undefined, alu_op=10, funct=000000 -> 1111; with it defined -> 0011.
